// File: rtl/raster_output_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : raster_output_dispatcher_pkg
//  Purpose : Shared types for the raster output dispatcher. It holds the
//            fragment payload, the colour and surface types, and the
//            dispatcher state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package raster_output_dispatcher_pkg;

  localparam int unsigned X_W = 12;
  localparam int unsigned Y_W = 12;
  localparam int unsigned T_W = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } RGB8;

  // ST_None marks a ray that hit nothing; its Color carries the clear colour.
  typedef enum logic [1:0] {
    ST_None        = 2'd0,
    ST_Opaque      = 2'd1,
    ST_Transparent = 2'd2,
    ST_Emissive    = 2'd3
  } SurfaceType;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    SurfaceType     surf;
    RGB8            Color;
    logic [T_W-1:0] t;
  } RasterOutputData;

  typedef enum logic [0:0] {
    DS_Idle = 1'b0,
    DS_Hold = 1'b1
  } DispatchState;

endpackage : raster_output_dispatcher_pkg
`default_nettype wire

// File: rtl/raster_output_dispatcher_frag_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : raster_frag_fifo
//  Purpose : Synchronous in-order FIFO of RasterOutputData with an occupancy
//            count and a registered almost-full flag (threshold DEPTH-1).
//  Ports   : clk, resetn (sync, active-low)
//            push_i / data_i      write side (dropped when full)
//            pop_i  / head_o      read side, head shown combinationally
//            count_o              occupancy, PTR_W+1 bits
//            almost_full_o        registered (next count >= DEPTH-1)
//  Rev     : 1.0  initial release
// ============================================================================
module raster_frag_fifo
  import raster_output_dispatcher_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            push_i,
  input  RasterOutputData data_i,
  input  logic            pop_i,
  output RasterOutputData head_o,
  output logic [PTR_W:0]  count_o,
  output logic            almost_full_o
);

  localparam int unsigned       CW      = PTR_W + 1;
  localparam logic [CW-1:0]     C_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]     C_AFULL = CW'(DEPTH - 1);

  RasterOutputData    mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic               afull_q,  afull_d;
  logic               w_full, w_empty, w_do_push, w_do_pop;

  // Full/empty come from the count so a wrapped pointer pair is never ambiguous.
  assign w_full    = (count_q == C_FULL);
  assign w_empty   = (count_q == '0);
  assign w_do_push = push_i && !w_full;
  assign w_do_pop  = pop_i && !w_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (w_do_push && !w_do_pop)      count_d = count_q + CW'(1);
    else if (!w_do_push && w_do_pop) count_d = count_q - CW'(1);
    // One slot stays free for the fragment already in flight from raster.
    afull_d = (count_d >= C_AFULL);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o        = mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign almost_full_o = afull_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (resetn && push_i) begin
      assert (!w_full) else $error("raster_frag_fifo: push while full, fragment dropped");
    end
  end
`endif

endmodule : raster_frag_fifo
`default_nettype wire

// File: rtl/raster_output_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module  : raster_output_dispatcher
//  Purpose : Buffers raster fragments in order. Hit fragments are sent to
//            the shadow stage and miss fragments (ST_None) to the
//            frame-buffer writer, with strict head-of-line ordering.
//  Ports   : clk, resetn (sync, active-low)
//            in_valid / in_data / output_fifo_full     raster side
//            shadow_fifo_full / shadow_valid / shadow_out  hit path
//            miss_fifo_full / miss_valid / miss_x / miss_y / miss_color
//            frag_count (wrapping), busy (queue non-empty)
//  Rev     : 1.0  initial release
// ============================================================================
module raster_output_dispatcher
  import raster_output_dispatcher_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  input  RasterOutputData in_data,
  output logic            output_fifo_full,
  input  logic            shadow_fifo_full,
  output logic            shadow_valid,
  output RasterOutputData shadow_out,
  input  logic            miss_fifo_full,
  output logic            miss_valid,
  output logic [X_W-1:0]  miss_x,
  output logic [Y_W-1:0]  miss_y,
  output RGB8             miss_color,
  output logic [31:0]     frag_count,
  output logic            busy
);

  RasterOutputData  w_head;
  logic [PTR_W:0]   w_count;
  logic             w_afull;
  logic             w_head_valid;
  logic             w_pop_shadow, w_pop_miss, w_pop;

  DispatchState     state_q, state_d;

  logic             shadow_valid_q, shadow_valid_d;
  RasterOutputData  shadow_out_q,   shadow_out_d;
  logic             miss_valid_q,   miss_valid_d;
  logic [X_W-1:0]   miss_x_q,       miss_x_d;
  logic [Y_W-1:0]   miss_y_q,       miss_y_d;
  RGB8              miss_color_q,   miss_color_d;
  logic [31:0]      frag_count_q,   frag_count_d;

  raster_frag_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .resetn        (resetn),
    .push_i        (in_valid),
    .data_i        (in_data),
    .pop_i         (w_pop),
    .head_o        (w_head),
    .count_o       (w_count),
    .almost_full_o (w_afull)
  );

  assign w_head_valid = (w_count != '0);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= DS_Idle;
    else         state_q <= state_d;
  end

  // Next state: every dispatch is followed by one bubble cycle so the
  // downstream registered full flags reflect the fragment just sent.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_Idle: if (w_pop) state_d = DS_Hold;
      DS_Hold: state_d = DS_Idle;
      default: state_d = DS_Idle;
    endcase
  end

  // Output decode: only the head is ever considered, so a blocked head
  // stalls both paths and order is preserved.
  always_comb begin
    w_pop_shadow = 1'b0;
    w_pop_miss   = 1'b0;
    if ((state_q == DS_Idle) && w_head_valid) begin
      if (w_head.surf != ST_None) w_pop_shadow = !shadow_fifo_full;
      else                        w_pop_miss   = !miss_fifo_full;
    end
    w_pop = w_pop_shadow | w_pop_miss;
  end

  always_comb begin
    shadow_valid_d = w_pop_shadow;
    shadow_out_d   = w_pop_shadow ? w_head : shadow_out_q;
    miss_valid_d   = w_pop_miss;
    miss_x_d       = w_pop_miss ? w_head.x     : miss_x_q;
    miss_y_d       = w_pop_miss ? w_head.y     : miss_y_q;
    miss_color_d   = w_pop_miss ? w_head.Color : miss_color_q;
    frag_count_d   = frag_count_q + {31'd0, w_pop};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shadow_valid_q <= 1'b0;
      shadow_out_q   <= '0;
      miss_valid_q   <= 1'b0;
      miss_x_q       <= '0;
      miss_y_q       <= '0;
      miss_color_q   <= '0;
      frag_count_q   <= '0;
    end else begin
      shadow_valid_q <= shadow_valid_d;
      shadow_out_q   <= shadow_out_d;
      miss_valid_q   <= miss_valid_d;
      miss_x_q       <= miss_x_d;
      miss_y_q       <= miss_y_d;
      miss_color_q   <= miss_color_d;
      frag_count_q   <= frag_count_d;
    end
  end

  assign output_fifo_full = w_afull;
  assign shadow_valid     = shadow_valid_q;
  assign shadow_out       = shadow_out_q;
  assign miss_valid       = miss_valid_q;
  assign miss_x           = miss_x_q;
  assign miss_y           = miss_y_q;
  assign miss_color       = miss_color_q;
  assign frag_count       = frag_count_q;
  assign busy             = w_head_valid;

endmodule : raster_output_dispatcher
`default_nettype wire

// File: tb/tb_raster_output_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module  : tb_raster_output_dispatcher
//  Purpose : Self-checking bench for raster_output_dispatcher. A queue-based
//            model predicts every output each cycle, and directed
//            scenarios add hand-computed literal expectations.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_raster_output_dispatcher;
  import raster_output_dispatcher_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            in_valid = 1'b0;
  RasterOutputData in_data = '0;
  logic            shadow_fifo_full = 1'b0;
  logic            miss_fifo_full = 1'b0;
  logic            output_fifo_full, shadow_valid, miss_valid, busy;
  RasterOutputData shadow_out;
  logic [X_W-1:0]  miss_x;
  logic [Y_W-1:0]  miss_y;
  RGB8             miss_color;
  logic [31:0]     frag_count;

  always #5 clk = ~clk;

  raster_output_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .output_fifo_full (output_fifo_full),
    .shadow_fifo_full (shadow_fifo_full),
    .shadow_valid     (shadow_valid),
    .shadow_out       (shadow_out),
    .miss_fifo_full   (miss_fifo_full),
    .miss_valid       (miss_valid),
    .miss_x           (miss_x),
    .miss_y           (miss_y),
    .miss_color       (miss_color),
    .frag_count       (frag_count),
    .busy             (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // A queue of pending fragments, plus a flag that forbids a dispatch in the
  // cycle right after one.
  RasterOutputData mq[$];
  bit              m_gap = 0;
  bit              m_on  = 0;
  bit              e_sv = 0, e_mv = 0;
  RasterOutputData e_sh = '0;
  logic [X_W-1:0]  e_mx = '0;
  logic [Y_W-1:0]  e_my = '0;
  RGB8             e_mc = '0;
  logic [31:0]     e_cnt = '0;
  int              dut_log[$];

  initial forever begin
    @(posedge clk);
    if (!resetn) begin
      mq.delete();
      m_gap = 0; e_sv = 0; e_mv = 0;
      e_sh = '0; e_mx = '0; e_my = '0; e_mc = '0; e_cnt = '0;
    end else begin
      int  occ;
      bit  took;
      took = 0;
      e_sv = 0;
      e_mv = 0;
      occ  = mq.size();
      if (!m_gap && occ > 0) begin
        if (mq[0].surf != ST_None) begin
          if (!shadow_fifo_full) begin e_sv = 1; e_sh = mq[0]; took = 1; end
        end else if (!miss_fifo_full) begin
          e_mv = 1; e_mx = mq[0].x; e_my = mq[0].y; e_mc = mq[0].Color; took = 1;
        end
      end
      if (took) begin
        void'(mq.pop_front());
        e_cnt = e_cnt + 1;
      end
      if (in_valid && occ < DEPTH) mq.push_back(in_data);
      m_gap = took;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_on) begin
      check("shadow_valid", shadow_valid, e_sv);
      check("miss_valid", miss_valid, e_mv);
      if (e_sv) check("shadow_out", shadow_out, e_sh);
      if (e_mv) begin
        check("miss_x", miss_x, e_mx);
        check("miss_y", miss_y, e_my);
        check("miss_color", miss_color, e_mc);
      end
      check("frag_count", frag_count, e_cnt);
      check("busy", busy, mq.size() != 0);
      check("output_fifo_full", output_fifo_full, mq.size() >= DEPTH - 1);
      if (shadow_valid) dut_log.push_back(int'(shadow_out.x));
      if (miss_valid)   dut_log.push_back(int'(miss_x));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input SurfaceType s, input int x, input int y, input logic [23:0] col);
    int guard;
    guard = 0;
    @(negedge clk);
    while (output_fifo_full && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      $display("FAIL push_wait: output_fifo_full stuck at %0b, required 0", output_fifo_full);
    end
    in_valid      = 1'b1;
    in_data.x     = X_W'(x);
    in_data.y     = Y_W'(y);
    in_data.surf  = s;
    in_data.Color = col;
    in_data.t     = T_W'(x * 3 + 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    bit done;
    done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy) done = 1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL drain_timeout: busy=%0b required 0", busy);
    end
    idle(1);
  endtask

  int base;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_full", output_fifo_full, 0);
    check("rst_sv", shadow_valid, 0);
    check("rst_mv", miss_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", frag_count, 0);
    check("rst_shadow_out", shadow_out, 0);
    resetn = 1'b1;
    m_on   = 1;

    // Single hit: 2-cycle latency, one-cycle strobe
    push(ST_Opaque, 5, 7, 24'h112233);
    #1 check("t1_sv_early", shadow_valid, 0);
    @(negedge clk); #1;
    check("t1_sv", shadow_valid, 1);
    check("t1_x", shadow_out.x, 5);
    check("t1_y", shadow_out.y, 7);
    check("t1_mv", miss_valid, 0);
    check("t1_cnt", frag_count, 1);
    @(negedge clk); #1;
    check("t1_sv_drop", shadow_valid, 0);
    idle(2);

    // Single miss
    push(ST_None, 0, 0, 24'h204060);
    @(negedge clk); #1;
    check("t2_mv", miss_valid, 1);
    check("t2_color", miss_color, 24'h204060);
    check("t2_sv", shadow_valid, 0);
    check("t2_cnt", frag_count, 2);
    idle(2);

    // Back-pressure: shadow stalled, 3 hits fill to the headroom threshold
    shadow_fifo_full = 1'b1;
    base = dut_log.size();
    push(ST_Opaque, 10, 1, 24'h0);
    push(ST_Transparent, 11, 2, 24'h0);
    #1 check("t3_full_at2", output_fifo_full, 0);
    push(ST_Emissive, 12, 3, 24'h0);
    #1 check("t3_full_at3", output_fifo_full, 1);
    idle(3);
    check("t3_no_strobe", dut_log.size() - base, 0);
    shadow_fifo_full = 1'b0;
    wait_drain(20);
    check("t3_n", dut_log.size() - base, 3);
    check("t3_o0", dut_log[base], 10);
    check("t3_o1", dut_log[base+1], 11);
    check("t3_o2", dut_log[base+2], 12);

    // Head-of-line blocking
    shadow_fifo_full = 1'b1;
    miss_fifo_full   = 1'b0;
    base = dut_log.size();
    push(ST_Opaque, 20, 0, 24'h0);
    push(ST_None, 21, 0, 24'h0a0b0c);
    idle(6);
    check("t4_blocked", dut_log.size() - base, 0);
    shadow_fifo_full = 1'b0;
    wait_drain(20);
    check("t4_n", dut_log.size() - base, 2);
    check("t4_o0", dut_log[base], 20);
    check("t4_o1", dut_log[base+1], 21);

    // Wrap: 10 mixed fragments with alternating stalls, from a clean reset
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    base = dut_log.size();
    fork
      begin
        for (int i = 0; i < 10; i++)
          push((i % 3 == 0) ? ST_None : ST_Opaque, 30 + i, i, 24'(i * 17));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          shadow_fifo_full = ((k % 5) < 2);
          miss_fifo_full   = ((k % 3) == 0);
        end
        @(negedge clk);
        shadow_fifo_full = 1'b0;
        miss_fifo_full   = 1'b0;
      end
    join
    wait_drain(40);
    check("t5_cnt", frag_count, 10);
    check("t5_busy", busy, 0);
    check("t5_n", dut_log.size() - base, 10);
    for (int i = 0; i < 10; i++)
      if (base + i < dut_log.size()) check($sformatf("t5_o%0d", i), dut_log[base+i], 30 + i);

    // Reset with entries queued
    shadow_fifo_full = 1'b1;
    push(ST_Opaque, 50, 0, 24'h0);
    push(ST_Opaque, 51, 0, 24'h0);
    #1 check("t6_busy_before", busy, 1);
    base = dut_log.size();
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); #1;
    check("t6_full", output_fifo_full, 0);
    check("t6_busy", busy, 0);
    check("t6_cnt", frag_count, 0);
    check("t6_sv", shadow_valid, 0);
    resetn = 1'b1;
    shadow_fifo_full = 1'b0;
    idle(3);
    check("t6_dropped", dut_log.size() - base, 0);
    push(ST_Opaque, 60, 4, 24'h0);
    #1 check("t6_sv_early", shadow_valid, 0);
    @(negedge clk); #1;
    check("t6_sv_lat", shadow_valid, 1);
    check("t6_x", shadow_out.x, 60);
    check("t6_cnt1", frag_count, 1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_raster_output_dispatcher
`default_nettype wire
